// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : rst_seq_pkg                                             |
// | Description: Shared types, default constants and sizing helpers for  |
// |              the rst_seq_pattern reset sequencer.                    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package rst_seq_pkg;

  // Sequencer states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ASSERT  = 2'd3
  } state_t;

  localparam int unsigned  c_def_width       = 24;
  localparam int unsigned  c_def_num_ch      = 4;
  localparam int unsigned  c_def_sync_stages = 2;
  localparam int unsigned  c_def_gap         = 4;
  localparam logic [23:0]  c_def_pattern     = 24'hC0FFEE;

  // The gap counter holds values 0..GAP-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned gap);
    return (gap <= 2) ? 1 : $clog2(gap);
  endfunction

  // Channel index register width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : rst_sync                                                |
// | Description: N-stage reset synchroniser. Asserts asynchronously with |
// |              rst_n, deasserts STAGES rising edges after rst_n rises. |
// | Ports      : clk        - clock                                      |
// |              rst_n      - asynchronous active-low reset input        |
// |              o_rst_sync - synchronised "out of reset" flag (1=run)   |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_rst_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : rst_seq_pattern                                         |
// | Description: Multi-channel reset sequencer. Releases NUM_CH channel  |
// |              resets GAP cycles apart after a synchronised board      |
// |              reset; each released channel loads PATTERN ^ index.     |
// |              A soft-reset request in RUN re-asserts the channels in  |
// |              reverse order and then re-runs the release sequence.    |
// | Ports      : clk          - clock                                    |
// |              rst_n        - asynchronous active-low board reset      |
// |              soft_rst_req - soft-reset request (level, RUN only)     |
// |              ch_rst_n     - per-channel active-low resets            |
// |              result       - per-channel result words, ch i at        |
// |                             [i*WIDTH +: WIDTH]                       |
// |              done         - all channels released and loaded         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module rst_seq_pattern
  import rst_seq_pkg::*;
#(
  parameter int unsigned       WIDTH       = c_def_width,
  parameter int unsigned       NUM_CH      = c_def_num_ch,
  parameter int unsigned       SYNC_STAGES = c_def_sync_stages,
  parameter int unsigned       GAP         = c_def_gap,
  parameter logic [WIDTH-1:0]  PATTERN     = WIDTH'(c_def_pattern)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_rst_req,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH*WIDTH-1:0] result,
  output logic                    done
);

  localparam int unsigned c_cnt_w = cnt_width(GAP);
  localparam int unsigned c_idx_w = idx_width(NUM_CH);

  localparam logic [c_cnt_w-1:0] c_gap_m1       = c_cnt_w'(GAP - 1);
  localparam logic [c_idx_w-1:0] c_idx_one      = c_idx_w'(1);
  localparam logic [c_idx_w-1:0] c_last_idx     = c_idx_w'(NUM_CH - 1);
  localparam logic [c_idx_w-1:0] c_first_assert = c_idx_w'((NUM_CH >= 2) ? NUM_CH - 2 : 0);

  // Elaboration-time parameter legality.
  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("rst_seq_pattern: NUM_CH must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_seq_pattern: SYNC_STAGES must be at least 2");
  end
  if (GAP < 1) begin : g_chk_gap
    $error("rst_seq_pattern: GAP must be at least 1");
  end
  if (WIDTH < $clog2(NUM_CH)) begin : g_chk_width
    $error("rst_seq_pattern: WIDTH must be at least clog2(NUM_CH)");
  end

  logic                w_rst_sync;
  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic                r_low;   // ASSERT: every channel already driven low
  logic [NUM_CH-1:0]   r_ch;
  logic                r_done;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_rst_sync (w_rst_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_low   <= 1'b0;
      r_ch    <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_rst_sync) begin
            r_ch[0] <= 1'b1;
            r_idx   <= c_idx_one;
            r_cnt   <= c_gap_m1;
            r_state <= (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (r_cnt == '0) begin
            r_ch[r_idx] <= 1'b1;
            r_cnt       <= c_gap_m1;
            if (r_idx == c_last_idx) begin
              r_state <= ST_RUN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_RUN: begin
          if (soft_rst_req) begin
            r_done         <= 1'b0;
            r_ch[NUM_CH-1] <= 1'b0;
            r_idx          <= c_first_assert;
            r_cnt          <= c_gap_m1;
            // A single channel is already fully asserted by this edge.
            r_low          <= (NUM_CH == 1);
            r_state        <= ST_ASSERT;
          end else begin
            r_done <= 1'b1;
          end
        end

        ST_ASSERT: begin
          if (r_cnt == '0) begin
            r_cnt <= c_gap_m1;
            if (r_low) begin
              // GAP edges after channel 0 fell: begin the release sequence.
              r_low   <= 1'b0;
              r_ch[0] <= 1'b1;
              r_idx   <= c_idx_one;
              r_state <= (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
            end else begin
              r_ch[r_idx] <= 1'b0;
              if (r_idx == '0) begin
                r_low <= 1'b1;
              end else begin
                r_idx <= r_idx - 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: r_state <= ST_HOLD;
      endcase
    end
  end

  // Result words follow the registered channel reset with one edge of lag.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_result
    logic [WIDTH-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (!r_ch[i]) begin
        r_word <= '0;
      end else begin
        r_word <= PATTERN ^ WIDTH'(i);
      end
    end

    assign result[i*WIDTH +: WIDTH] = r_word;
  end

  assign ch_rst_n = r_ch;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_rst_seq_pattern                                      |
// | Description: Scoreboard bench for rst_seq_pattern. A reference model |
// |              built from event times pushes the expected outputs for  |
// |              every edge; a monitor pops and compares on the falling  |
// |              edge. A second instance covers NUM_CH=1, GAP=1, S=3.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_rst_seq_pattern;

  localparam int          WIDTH  = 24;
  localparam int          NUM_CH = 4;
  localparam int          S      = 2;
  localparam int          GAP    = 4;
  localparam logic [23:0] PAT    = 24'hC0FFEE;
  localparam int          CW     = NUM_CH * WIDTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              soft_rst_req;
  logic [NUM_CH-1:0] ch_rst_n;
  logic [CW-1:0]     result;
  logic              done;

  logic              rst2_n;
  logic              soft2;
  logic [0:0]        ch2;
  logic [WIDTH-1:0]  result2;
  logic              done2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rst_seq_pattern #(
    .WIDTH (WIDTH), .NUM_CH (NUM_CH), .SYNC_STAGES (S), .GAP (GAP), .PATTERN (PAT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .soft_rst_req (soft_rst_req),
    .ch_rst_n (ch_rst_n), .result (result), .done (done)
  );

  rst_seq_pattern #(
    .WIDTH (WIDTH), .NUM_CH (1), .SYNC_STAGES (3), .GAP (1), .PATTERN (PAT)
  ) dut1 (
    .clk (clk), .rst_n (rst2_n), .soft_rst_req (soft2),
    .ch_rst_n (ch2), .result (result2), .done (done2)
  );

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: per-channel rise/fall edge numbers derived from the
  // release/assert schedule; the expected outputs for each edge are
  // queued for the monitor.
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [NUM_CH-1:0] ch;
    logic [CW-1:0]     res;
    logic              done;
  } exp_t;

  exp_t              exp_q[$];
  int                m_x = -1;
  int                rise_at[NUM_CH];
  int                fall_at[NUM_CH];
  int                done_at = 0;
  logic [NUM_CH-1:0] m_ch = '0;

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (!rst_n) begin
      m_x  = -1;
      m_ch = '0;
    end else begin
      m_x = m_x + 1;
      if (m_x == 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          rise_at[i] = S + i * GAP;
          fall_at[i] = -1;
        end
        done_at = S + (NUM_CH - 1) * GAP + 1;
      end
      // Result reflects the channel reset state from before this edge.
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_ch[i]) e.res[i*WIDTH +: WIDTH] = PAT ^ WIDTH'(i);
      end
      // Edges at or beyond done_at are RUN edges: a request is honoured.
      if (m_x >= done_at && soft_rst_req) begin
        for (int k = 0; k < NUM_CH; k++) fall_at[NUM_CH-1-k] = m_x + k * GAP;
        for (int i = 0; i < NUM_CH; i++) rise_at[i] = m_x + NUM_CH * GAP + i * GAP;
        done_at = m_x + (2 * NUM_CH - 1) * GAP + 1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_x >= rise_at[i])      m_ch[i] = 1'b1;
        else if (m_x >= fall_at[i]) m_ch[i] = 1'b0;
      end
      e.ch   = m_ch;
      e.done = (m_x >= done_at);
    end
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ch_rst_n", CW'(ch_rst_n), CW'(e.ch));
      check("result",   result,        e.res);
      check("done",     CW'(done),     CW'(e.done));
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drop rst_n mid-cycle and confirm the outputs clear without a clock.
  task automatic drop_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_ch",     CW'(ch_rst_n), '0);
    check("async_result", result,        '0);
    check("async_done",   CW'(done),     '0);
  endtask

  initial begin
    rst_n        = 1'b0;
    rst2_n       = 1'b0;
    soft_rst_req = 1'b0;
    soft2        = 1'b0;
    #2;
    check("reset_ch",     CW'(ch_rst_n), '0);
    check("reset_result", result,        '0);
    check("reset_done",   CW'(done),     '0);

    // Power-on release sequence.
    edges(2);
    release_rst();
    edges(20);

    // Single-cycle soft-reset pulse in RUN.
    soft_rst_req = 1'b1;
    edges(1);
    soft_rst_req = 1'b0;
    edges(35);

    // Board reset dropped after E8, then a full restart.
    drop_rst();
    edges(2);
    release_rst();
    edges(9);
    drop_rst();
    edges(2);
    release_rst();
    edges(20);

    // Request held through RELEASE only: ignored.
    drop_rst();
    edges(2);
    release_rst();
    edges(4);
    soft_rst_req = 1'b1;
    edges(11);
    soft_rst_req = 1'b0;
    edges(5);

    // Request held into RUN: retriggers on each RUN entry.
    drop_rst();
    edges(1);
    release_rst();
    edges(6);
    soft_rst_req = 1'b1;
    edges(50);
    soft_rst_req = 1'b0;
    edges(35);

    // Randomised pulses and resets.
    for (int it = 0; it < 10; it++) begin
      edges($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) begin
        drop_rst();
        edges($urandom_range(1, 3));
        release_rst();
      end else begin
        soft_rst_req = 1'b1;
        edges($urandom_range(1, 3));
        soft_rst_req = 1'b0;
      end
    end
    edges(40);

    // Single-channel instance: NUM_CH=1, GAP=1, S=3.
    check("one_reset_ch",   CW'(ch2),   '0);
    check("one_reset_done", CW'(done2), '0);
    @(posedge clk);
    #2 rst2_n = 1'b1;
    edges(3);
    check("one_ch_E2",     CW'(ch2),     '0);
    edges(1);
    check("one_ch_E3",     CW'(ch2),     CW'(1));
    check("one_result_E3", CW'(result2), '0);
    check("one_done_E3",   CW'(done2),   '0);
    edges(1);
    check("one_result_E4", CW'(result2), CW'(PAT));
    check("one_done_E4",   CW'(done2),   CW'(1));

    edges(1);
    @(negedge clk);
    #1;
    check("queue_drained", CW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rst_seq_pattern.md
# rst_seq_pattern

Parametrised multi-channel reset sequencer with per-channel pattern registers. It synchronises deassertion of the board reset and releases NUM_CH channel resets one at a time, GAP cycles apart. Each channel's result register loads a channel-tagged constant once its reset is released. A soft-reset request re-asserts the channels in reverse order and then re-runs the release sequence. The block sits at the top of each subsystem and feeds its downstream reset domains.

## Interface
- WIDTH, 24: width of each channel result word.
- NUM_CH, 4: number of sequenced channels; must be at least 1.
- SYNC_STAGES, 2: depth of the deassertion synchroniser; must be at least 2.
- GAP, 4: cycles between successive channel release or assert events; must be at least 1.
- PATTERN, 24'hC0FFEE: base load value, WIDTH bits; must satisfy WIDTH >= clog2(NUM_CH).
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- soft_rst_req  input  1  soft-reset request, level, sampled only in RUN.
- ch_rst_n  output  NUM_CH  per-channel active-low reset; bit i belongs to channel i.
- result  output  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- done  output  1  high while all channels are released and loaded.

## Operation
- rst_n low forces these values immediately, with no clock needed:
  - ch_rst_n = 0, result = 0, done = 0;
  - synchroniser flops = 0, FSM = HOLD, gap counter = 0, channel index = 0.
- Synchroniser: asserts asynchronously; deasserts after SYNC_STAGES rising edges with rst_n high. Its output is rst_sync.
- FSM states:
  - HOLD: wait for rst_sync = 1. On the next edge, set ch_rst_n[0] = 1, index = 1, counter = GAP-1, and go to RELEASE. If NUM_CH = 1, go straight to RUN.
  - RELEASE: count down each edge. At counter = 0, set ch_rst_n[index] = 1 and reload the counter. After the last channel is released, go to RUN.
  - RUN: done = 1, registered one edge after the last result loads. When soft_rst_req = 1 is sampled:
    - done <= 0 and ch_rst_n[NUM_CH-1] <= 0 on the same edge;
    - go to ASSERT with index = NUM_CH-2 and counter = GAP-1.
  - ASSERT: at counter = 0, clear ch_rst_n[index] and move toward index 0. GAP edges after ch_rst_n[0] falls, set ch_rst_n[0] = 1 and continue exactly as in RELEASE.
- Result register, channel i:
  - async clear on rst_n;
  - on each edge, if the registered ch_rst_n[i] = 0, result[i] <= 0; otherwise result[i] <= PATTERN ^ i.
  - So result[i] loads one edge after ch_rst_n[i] rises and clears one edge after it falls.
- soft_rst_req outside RUN is ignored, with no latching. Held high, it retriggers on each entry to RUN.
- rst_n low at any point, including mid-RELEASE or mid-ASSERT, aborts the sequence. Full restart from HOLD follows deassertion.

## Timing
- E0 is the first rising edge with rst_n high. Let S = SYNC_STAGES.
- rst_sync is high after edge E(S-1).
- ch_rst_n[i] rises at E(S + i*GAP).
- result[i] is valid after E(S + i*GAP + 1).
- done rises at E(S + (NUM_CH-1)*GAP + 1).
- Soft-reset request sampled at edge R:
  - ch_rst_n[NUM_CH-1-k] falls at R + k*GAP;
  - ch_rst_n[0] rises at R + NUM_CH*GAP;
  - done rises at R + (2*NUM_CH-1)*GAP + 1.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Package rst_seq_pkg holds:
  - the state enum typedef (HOLD, RELEASE, RUN, ASSERT);
  - default parameter constants;
  - a counter-width function based on clog2(GAP).
- Sub-module rst_sync: an N-stage synchroniser with asynchronous assert and synchronous deassert. The parent instantiates it once.
- Parameter legality is checked at elaboration.

## Test plan
Defaults are NUM_CH=4, GAP=4, S=2, WIDTH=24 unless stated.
- Power-on, rst_n released before E0:
  - ch_rst_n = 0001 after E2, 0011 after E6, 0111 after E10, 1111 after E14;
  - result = C0FFEE after E3, C0FFEF after E7, C0FFEC after E11, C0FFED after E15;
  - done = 1 after E15.
- rst_n dropped between edges after E8: all outputs read 0 before the next clock edge. After re-release, the timing repeats the power-on case exactly.
- soft_rst_req pulse sampled at edge R in RUN:
  - ch_rst_n = 0111 at R, 0011 at R+4, 0001 at R+8, 0000 at R+12, 0001 at R+16;
  - result[3] = 0 after R+1;
  - done = 0 from R until R+29.
- soft_rst_req held high during RELEASE: no effect, and done rises at E15. Still high on entering RUN: a soft sequence starts at the first RUN edge.
- NUM_CH=1, GAP=1, S=3: ch_rst_n = 1 after E3; result = C0FFEE and done = 1 after E4.
